// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect, and decode handoff.
// master = fetch unit, slave = memory/decode side.
interface ifu_prefetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: owns the PC, issues in-order fetches, queues returned words with their
// PCs and hands them to decode. Redirect flushes the queue and discards in-flight responses.
module ifu_prefetch #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic          clock,
    input  logic          reset_n,
    ifu_prefetch_if.master bus
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc, rsp_pc, redirect_base;
    logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      q_count, outstanding, drop_cnt;
    logic [CNT_W:0]        reserved;
    logic                  running, head_valid;
    logic                  redirect, req_valid, req_fire, rsp_take, push, pop;
    logic                  redirect_pc_unused;

    // Low address bits of a redirect target are forced to zero and never read.
    assign redirect_pc_unused = ^bus.redirect_pc[1:0];
    assign redirect_base      = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign redirect           = bus.redirect_valid;

    // Queue slots are reserved at request time, so a response always has room.
    assign reserved  = {1'b0, q_count} + {1'b0, outstanding};
    assign req_valid = running && !redirect && (reserved < DEPTH_C);
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign rsp_take  = bus.imem_rsp_valid && (outstanding != '0);
    assign push      = !redirect && rsp_take && (drop_cnt == '0);
    assign head_valid = (q_count != '0);
    assign pop       = head_valid && bus.inst_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = head_valid;
    assign bus.inst_data      = head_valid ? q_data[rd_ptr] : '0;
    assign bus.inst_pc        = head_valid ? q_pc[rd_ptr]   : '0;

    // running holds off the first request until the edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            running     <= 1'b0;
            fetch_pc    <= RESET_VECTOR;
            rsp_pc      <= RESET_VECTOR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            q_count     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            running <= 1'b1;
            if (redirect) begin
                fetch_pc    <= redirect_base;
                rsp_pc      <= redirect_base;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                q_count     <= '0;
                outstanding <= outstanding - CNT_W'(rsp_take);
                drop_cnt    <= outstanding - CNT_W'(rsp_take);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);
                if (rsp_take && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CNT_W'(1);
                if (push) begin
                    rsp_pc <= rsp_pc + ADDR_WIDTH'(4);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_data[wr_ptr] <= bus.imem_rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
        end
    end
endmodule
